// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, DATA_BITS data bits LSB first, optional parity, STOP_BITS stop bits.
// One bit per rising edge of tx_clk (a data input sampled on clk); parity feature enabled by `UART_TX_PARITY_EN.
module uart_tx_frame #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_clk,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                 parity_odd,
`endif
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {IDLE, WAIT, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_d;
  logic                 tx_clk_q;
  logic                 tick;
  logic                 accept;
  logic [DATA_BITS-1:0] shift, shift_d;
  logic [CW-1:0]        count, count_d;
  logic                 stop_cnt, stop_cnt_d;
  logic                 tx_d;
  logic                 done_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  // Handshake: a byte is taken in any clk cycle where tx_valid and tx_ready are both high;
  // tx_ready is high only in IDLE, and tx_valid in any other cycle is ignored (nothing is queued).
  assign tick     = tx_clk & ~tx_clk_q;
  assign tx_ready = (state == IDLE);
  assign tx_busy  = (state != IDLE);
  assign accept   = tx_valid & tx_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_clk_q <= 1'b0;
      tx       <= 1'b1;
      tx_done  <= 1'b0;
      shift    <= '0;
      count    <= '0;
      stop_cnt <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q    <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      tx_clk_q <= tx_clk;
      tx       <= tx_d;
      tx_done  <= done_d;
      shift    <= shift_d;
      count    <= count_d;
      stop_cnt <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
      par_q    <= par_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    tx_d       = tx;
    shift_d    = shift;
    count_d    = count;
    stop_cnt_d = stop_cnt;
    done_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif
    case (state)
      IDLE: begin
        // A tick coinciding with the accept is deliberately not acted on here.
        if (accept) begin
          shift_d    = tx_data;
          count_d    = '0;
          stop_cnt_d = 1'b0;
          state_d    = WAIT;
`ifdef UART_TX_PARITY_EN
          par_d      = (^tx_data) ^ parity_odd;
`endif
        end
      end
      WAIT: begin
        if (tick) begin
          tx_d    = 1'b0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          tx_d    = shift[0];
          shift_d = shift >> 1;
          count_d = CW'(1);
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          if (count < LAST_CNT) begin
            tx_d    = shift[0];
            shift_d = shift >> 1;
            count_d = count + CW'(1);
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d    = par_q;
            state_d = PARITY;
`else
            tx_d    = 1'b1;
            state_d = STOP;
`endif
          end
        end
      end
      PARITY: begin
        if (tick) begin
          tx_d    = 1'b1;
          state_d = STOP;
        end
      end
      STOP: begin
        // The stop bit is already on the line; each tick here ends one stop period.
        if (tick) begin
          if (stop_cnt == STOP_LAST) begin
            state_d    = IDLE;
            done_d     = 1'b1;
            count_d    = '0;
            stop_cnt_d = 1'b0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
